// File: rtl/io_input_conditioner.sv
// Synchronises and debounces the board switches and active-low keys into io_input_bus.
// Optional build macro KEY_TOGGLE_EN turns each key output into a press-toggled flop.
module io_input_conditioner #(
    parameter int N_SW            = 10,
    parameter int N_KEY           = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_SW-1:0]         sw,
    input  logic [N_KEY-1:0]        key_n,
    output logic [N_SW+N_KEY-1:0]   io_input_bus
);

    localparam int N     = N_SW + N_KEY;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    // Keys idle high (released), switches idle low.
    localparam logic [N-1:0]     RST_VAL = {{N_KEY{1'b1}}, {N_SW{1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0]     raw;
    logic [N-1:0]     sync1_q;
    logic [N-1:0]     sync2_q;
    logic [N-1:0]     stable_q;
    logic [N-1:0]     stable_d;
    logic [CNT_W-1:0] cnt_q [N];
    logic [CNT_W-1:0] cnt_d [N];
    logic [N_KEY-1:0] key_out;

    assign raw = {key_n, sw};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= RST_VAL;
            sync2_q <= RST_VAL;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stable_q <= RST_VAL;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef KEY_TOGGLE_EN
    logic [N_KEY-1:0] key_tog_q;
    logic [N_KEY-1:0] key_press;

    // A debounced press is the stable key level falling 1->0 on this edge.
    assign key_press = stable_q[N-1:N_SW] & ~stable_d[N-1:N_SW];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            key_tog_q <= '0;
        end else begin
            key_tog_q <= key_tog_q ^ key_press;
        end
    end

    assign key_out = key_tog_q;
`else
    assign key_out = ~stable_q[N-1:N_SW];
`endif

    assign io_input_bus = {key_out, stable_q[N_SW-1:0]};

endmodule

// File: tb/tb_io_input_conditioner.sv
// Scoreboard bench for io_input_conditioner with DEBOUNCE_CYCLES=4 and a window-based reference model.
module tb_io_input_conditioner;

    localparam int N_SW  = 10;
    localparam int N_KEY = 4;
    localparam int N     = N_SW + N_KEY;
    localparam int D     = 4;
    localparam logic [N-1:0] RST_VAL = {4'hF, 10'h000};

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [N_SW-1:0]   sw    = '0;
    logic [N_KEY-1:0]  key_n = '1;
    logic [N-1:0]      io_input_bus;

    int checks   = 0;
    int failures = 0;

    io_input_conditioner #(
        .N_SW(N_SW),
        .N_KEY(N_KEY),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clock(clock),
        .reset(reset),
        .sw(sw),
        .key_n(key_n),
        .io_input_bus(io_input_bus)
    );

    always #5 clock = ~clock;

    // Reference model: a bit's accepted level flips at edge k when the synchronised
    // input seen at each of the last D edges differed from it and no flip/reset
    // happened inside that window. Synchronised input at edge j is the pin value
    // sampled two edges earlier (reset level for the first two edges).
    logic [N-1:0]     samp [$];
    logic [N-1:0]     exp_q [$];
    logic [N-1:0]     m_stable;
    logic [N_KEY-1:0] m_tog;
    int               last_evt [N];
    int               k;

    task automatic model_reset();
        samp.delete();
        m_stable = RST_VAL;
        m_tog    = '0;
        k        = 0;
        for (int i = 0; i < N; i++) last_evt[i] = 0;
    endtask

    function automatic logic [N-1:0] seen(input int j);
        if (j < 3) return RST_VAL;
        return samp[j-3];
    endfunction

    function automatic logic [N-1:0] expected_bus();
`ifdef KEY_TOGGLE_EN
        return {m_tog, m_stable[N_SW-1:0]};
`else
        return {~m_stable[N-1:N_SW], m_stable[N_SW-1:0]};
`endif
    endfunction

    task automatic model_edge(input logic [N-1:0] raw_v);
        logic [N-1:0] nxt;
        logic [N-1:0] s;
        bit           all_diff;
        k++;
        samp.push_back(raw_v);
        nxt = m_stable;
        for (int i = 0; i < N; i++) begin
            if (k - last_evt[i] >= D) begin
                all_diff = 1'b1;
                for (int j = k - D + 1; j <= k; j++) begin
                    s = seen(j);
                    if (s[i] == m_stable[i]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    nxt[i]      = ~m_stable[i];
                    last_evt[i] = k;
                end
            end
        end
        for (int i = 0; i < N_KEY; i++) begin
            if (m_stable[N_SW+i] && !nxt[N_SW+i]) m_tog[i] = ~m_tog[i];
        end
        m_stable = nxt;
        exp_q.push_back(expected_bus());
    endtask

    // Drive pins between edges, predict the next edge, then advance one cycle.
    task automatic step(input logic [N_SW-1:0] s, input logic [N_KEY-1:0] kn);
        sw    = s;
        key_n = kn;
        model_edge({kn, s});
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic check_bus0(input string name);
        checks++;
        if (io_input_bus !== '0) begin
            failures++;
            $display("FAIL %s t=%0t got=%h exp=0000", name, $time, io_input_bus);
        end
    endtask

    initial begin : monitor
        logic [N-1:0] e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (io_input_bus !== e) begin
                    failures++;
                    $display("FAIL bus_edge t=%0t got=%h exp=%h", $time, io_input_bus, e);
                end
            end
        end
    end

    initial begin : stim
        logic [N_SW-1:0]  cs;
        logic [N_KEY-1:0] ck;

        // Reset values, asserted with all inputs active.
        sw    = 10'h3FF;
        key_n = 4'h0;
        #1 reset = 1'b0;
        #1 check_bus0("reset_async");
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_bus0("reset_hold");
        end
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) step(10'h3FF, 4'h0);

        // Return to idle, then switch 0 rising edge.
        for (int i = 0; i < 10; i++) step(10'h000, 4'hF);
        for (int i = 0; i < 10; i++) step(10'h001, 4'hF);

        // Glitch rejection on switch 3: 3 cycles high, 1 low, five times.
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 3; i++) step(10'h009, 4'hF);
            step(10'h001, 4'hF);
        end
        for (int i = 0; i < 6; i++) step(10'h001, 4'hF);

        // Key 2 press held 20 cycles, then release.
        for (int i = 0; i < 20; i++) step(10'h001, 4'hB);
        for (int i = 0; i < 10; i++) step(10'h001, 4'hF);

        // Switch 5 rises; reset asserted two edges into counting.
        for (int i = 0; i < 4; i++) step(10'h021, 4'hF);
        reset = 1'b0;
        #1 check_bus0("reset_mid_count");
        @(negedge clock);
        check_bus0("reset_mid_hold");
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) step(10'h021, 4'hF);

        // Two clean presses of key 0 (toggle behaviour when the build enables it).
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 10; i++) step(10'h021, 4'hE);
            for (int i = 0; i < 10; i++) step(10'h021, 4'hF);
        end

        // Random pin activity: each bit flips with probability 1/8 per cycle.
        cs = 10'h021;
        ck = 4'hF;
        for (int n = 0; n < 600; n++) begin
            for (int b = 0; b < N_SW; b++)
                if ($urandom_range(7) == 0) cs[b] = ~cs[b];
            for (int b = 0; b < N_KEY; b++)
                if ($urandom_range(7) == 0) ck[b] = ~ck[b];
            step(cs, ck);
        end
        for (int i = 0; i < 8; i++) step(cs, ck);

        @(posedge clock);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
